// File: rtl/vga_pkg.sv
// Shared constants, pixel types and colour expansion for the VGA pixel fetch slice.
package vga_pkg;

  localparam int H_ACTIVE_D = 480;
  localparam int V_ACTIVE_D = 320;
  localparam int PIPE_LAT   = 3;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic rgb888_t expand332(input rgb332_t p);
    rgb888_t o;
    o.r = {p.r, p.r, p.r[2:1]};
    o.g = {p.g, p.g, p.g[2:1]};
    o.b = {p.b, p.b, p.b, p.b};
    return o;
  endfunction

endpackage

// File: rtl/vga_scale_counter.sv
// Sub-step plus coordinate counter: coord advances once every SUB_N steps.
// A load forces both fields to zero in the same cycle it is asserted.
module vga_scale_counter #(
  parameter int SUB_N   = 2,
  parameter int COORD_N = 160,
  parameter int SUB_W   = 1,
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  output logic [COORD_W-1:0] coord,
  output logic               wrap
);

  logic [SUB_W-1:0]   sub_q;
  logic [SUB_W-1:0]   sub;
  logic [COORD_W-1:0] coord_q;

  // Loaded values are visible immediately so the first window pixel addresses column 0.
  always_comb begin
    sub   = sub_q;
    coord = coord_q;
    if (load) begin
      sub   = '0;
      coord = '0;
    end else begin
      sub   = sub_q;
      coord = coord_q;
    end
    wrap = (sub == SUB_W'(SUB_N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q   <= '0;
      coord_q <= '0;
    end else if (step) begin
      if (wrap) begin
        sub_q   <= '0;
        coord_q <= (coord == COORD_W'(COORD_N - 1)) ? '0 : coord + COORD_W'(1);
      end else begin
        sub_q   <= sub + SUB_W'(1);
        coord_q <= coord;
      end
    end else if (load) begin
      sub_q   <= '0;
      coord_q <= '0;
    end else begin
      sub_q   <= sub_q;
      coord_q <= coord_q;
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer address generation and RGB/sync alignment for an upscaled image window.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int         H_ACTIVE = H_ACTIVE_D,
  parameter int         V_ACTIVE = V_ACTIVE_D,
  parameter int         IMG_W    = 160,
  parameter int         IMG_H    = 160,
  parameter int         SCALE    = 2,
  parameter int         X_OFF    = 80,
  parameter int         Y_OFF    = 0,
  parameter int         ADDR_W   = 15,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              hsync_in,
  input  logic              vsync_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_n,
  output logic [7:0]        frame_count
);

  localparam int SUB_W  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int X_SPAN = IMG_W * SCALE;
  localparam int Y_SPAN = IMG_H * SCALE;

  typedef struct packed {
    logic vis;
    logic win;
    logic hsync;
    logic vsync;
  } tag_t;

  logic [31:0]       h_ext;
  logic [31:0]       v_ext;
  logic              vis;
  logic              win;
  logic              y_line;
  logic              x_load;
  logic              y_step;
  logic              eof;
  logic [XW-1:0]     x_img;
  logic [YW-1:0]     y_img;
  logic              x_wrap_unused;
  logic              y_wrap;
  logic [ADDR_W-1:0] row_base;
  tag_t              stg [PIPE_LAT-1];
  rgb888_t           pix;

  // Offsets are subtracted unsigned so counts left of the window wrap to huge values.
  assign h_ext  = {22'd0, h_count};
  assign v_ext  = {22'd0, v_count};
  assign vis    = (h_ext < 32'(H_ACTIVE)) && (v_ext < 32'(V_ACTIVE));
  assign y_line = (v_ext - 32'(Y_OFF)) < 32'(Y_SPAN);
  assign win    = vis && y_line && ((h_ext - 32'(X_OFF)) < 32'(X_SPAN));
  assign x_load = (h_ext == 32'(X_OFF));
  assign y_step = y_line && (h_ext == 32'(X_OFF + X_SPAN));
  assign eof    = (h_ext == 32'd0) && (v_ext == 32'(V_ACTIVE));

  vga_scale_counter #(
    .SUB_N  (SCALE),
    .COORD_N(IMG_W),
    .SUB_W  (SUB_W),
    .COORD_W(XW)
  ) u_x_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (x_load),
    .step (win),
    .coord(x_img),
    .wrap (x_wrap_unused)
  );

  vga_scale_counter #(
    .SUB_N  (SCALE),
    .COORD_N(IMG_H),
    .SUB_W  (SUB_W),
    .COORD_W(YW)
  ) u_y_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (eof),
    .step (y_step),
    .coord(y_img),
    .wrap (y_wrap)
  );

  // Row base clears after the last image row so the address never leaves the image.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base <= '0;
    end else if (eof) begin
      row_base <= '0;
    end else if (y_step && y_wrap) begin
      row_base <= (y_img == YW'(IMG_H - 1)) ? '0 : row_base + ADDR_W'(IMG_W);
    end else begin
      row_base <= row_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr    <= '0;
      frame_count <= 8'd0;
    end else begin
      mem_addr    <= win ? (row_base + ADDR_W'(x_img)) : mem_addr;
      frame_count <= eof ? (frame_count + 8'd1) : frame_count;
    end
  end

  // Flag/sync delay line; syncs idle high so reset never emits a sync pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
        stg[i] <= '{vis: 1'b0, win: 1'b0, hsync: 1'b1, vsync: 1'b1};
      end
    end else begin
      stg[0] <= '{vis: vis, win: win, hsync: hsync_in, vsync: vsync_in};
      for (int i = 1; i < PIPE_LAT - 1; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [7:0] x_img8;
  logic [2:0] bar_d [PIPE_LAT-1];
  logic       pat_d [PIPE_LAT-1];

  assign x_img8 = 8'(x_img);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT - 1; i++) begin
        bar_d[i] <= 3'd0;
        pat_d[i] <= 1'b0;
      end
    end else begin
      bar_d[0] <= x_img8[7:5];
      pat_d[0] <= pattern_sel;
      for (int i = 1; i < PIPE_LAT - 1; i++) begin
        bar_d[i] <= bar_d[i-1];
        pat_d[i] <= pat_d[i-1];
      end
    end
  end
`endif

  always_comb begin
    pix = '0;
    if (!stg[PIPE_LAT-2].vis) begin
      pix = '0;
    end else if (!stg[PIPE_LAT-2].win) begin
      pix = expand332(rgb332_t'(BG_COLOR));
    end else begin
`ifdef VGA_TEST_PATTERN_EN
      if (pat_d[PIPE_LAT-2]) begin
        pix = expand332(rgb332_t'({bar_d[PIPE_LAT-2], bar_d[PIPE_LAT-2], bar_d[PIPE_LAT-2][1:0]}));
      end else begin
        pix = expand332(rgb332_t'(mem_rdata));
      end
`else
      pix = expand332(rgb332_t'(mem_rdata));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red       <= 8'd0;
      green     <= 8'd0;
      blue      <= 8'd0;
      blank_n   <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      red       <= pix.r;
      green     <= pix.g;
      blue      <= pix.b;
      blank_n   <= stg[PIPE_LAT-2].vis;
      hsync_out <= stg[PIPE_LAT-2].hsync;
      vsync_out <= stg[PIPE_LAT-2].vsync;
    end
  end

endmodule
